// File: rtl/switch_unpack.sv
// Receive side of the sign-select 3-bit switch: undoes the token inversion and pairs an
// upper-half token with a lower-half token into a 6-bit word on a valid/ready output.
module switch_unpack #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [2:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       word_out,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        StWaitHi = 2'd0,
        StWaitLo = 2'd1,
        StFull   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       hi_q, hi_d;
    logic [5:0]       word_q, word_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             accept;
    logic             order_err;

    // in_ready depends on registered state only, never on out_ready.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q == StFull);
    assign accept    = in_valid && in_ready;
    assign word_out  = word_q;
    assign err       = err_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        order_err  = 1'b0;

        if (clr) begin
            // Flush any partial or held word; a coincident handshake is discarded.
            state_d = StWaitHi;
            hi_d    = '0;
        end else begin
            unique case (state_q)
                StWaitHi: begin
                    if (accept) begin
                        if (in_sel) begin
                            hi_d    = ~in_data;
                            state_d = StWaitLo;
                        end else begin
                            order_err = 1'b1;
                        end
                    end
                end
                StWaitLo: begin
                    if (accept) begin
                        if (in_sel) begin
                            // Newest upper half wins.
                            hi_d      = ~in_data;
                            order_err = 1'b1;
                        end else begin
                            word_d  = {hi_q, ~in_data};
                            state_d = StFull;
                        end
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        state_d    = StWaitHi;
                    end
                end
                default: begin
                    state_d = StWaitHi;
                end
            endcase
        end
    end

    always_comb begin
        err_d     = order_err;
        err_cnt_d = err_cnt_q;
        if (order_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StWaitHi;
            hi_q       <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            word_q     <= word_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_switch_unpack.sv
// Bench for switch_unpack: directed scenarios plus random traffic, all checked against a
// transaction-level model (pending upper half, queue of held words, running totals).
module tb_switch_unpack;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [2:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] word_out;
    logic       err;
    logic [7:0] word_cnt;
    logic [7:0] err_cnt;

    int n_vec;
    int n_bad;

    // Reference model state.
    bit         m_have_hi;
    logic [2:0] m_hi;
    logic [5:0] m_held[$];
    logic [5:0] m_last;
    bit         m_err;
    int         m_words;
    int         m_errors;

    switch_unpack #(
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_out (word_out),
        .err      (err),
        .word_cnt (word_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_hi      = '0;
        m_held.delete();
        m_last    = '0;
        m_err     = 1'b0;
        m_words   = 0;
        m_errors  = 0;
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (clr) begin
            m_have_hi = 1'b0;
            m_held.delete();
        end else if (m_held.size() != 0) begin
            if (out_ready) begin
                void'(m_held.pop_front());
                m_words++;
            end
        end else if (in_valid) begin
            if (in_sel) begin
                if (m_have_hi) m_err = 1'b1;
                m_have_hi = 1'b1;
                m_hi      = ~in_data;
            end else if (m_have_hi) begin
                m_last = {m_hi, ~in_data};
                m_held.push_back(m_last);
                m_have_hi = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (m_err) m_errors++;
    endtask

    task automatic check_model();
        check_eq("out_valid", 32'(out_valid), 32'(m_held.size() != 0));
        check_eq("in_ready", 32'(in_ready), 32'(m_held.size() == 0));
        check_eq("word_out", 32'(word_out), 32'(m_last));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("word_cnt", 32'(word_cnt), 32'(m_words % 256));
        check_eq("err_cnt", 32'(err_cnt), 32'((m_errors > 255) ? 255 : m_errors));
    endtask

    // Apply inputs for one cycle, advance model and DUT, compare just after the edge.
    task automatic drive(input logic v, input logic s, input logic [2:0] d, input logic ordy,
                         input logic c);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        clr       = c;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [2:0] hi, input logic [2:0] lo);
        drive(1'b1, 1'b1, hi, 1'b1, 1'b0);
        drive(1'b1, 1'b0, lo, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_word_out", 32'(word_out), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Basic pairing: ~010 = 101, ~011 = 100.
        drive(1'b1, 1'b1, 3'b010, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
        check_eq("pair_valid", 32'(out_valid), 32'd1);
        check_eq("pair_word", 32'(word_out), 32'b101100);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
        check_eq("pair_cnt", 32'(word_cnt), 32'd1);

        // Backpressure in FULL with tokens offered.
        drive(1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
        check_eq("bp_ready", 32'(in_ready), 32'd0);
        check_eq("bp_word", 32'(word_out), 32'b001110);
        drive(1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
        check_eq("bp_done_ready", 32'(in_ready), 32'd1);
        check_eq("bp_cnt", 32'(word_cnt), 32'd2);

        // Ordering errors.
        drive(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
        check_eq("lo_first_err", 32'(err), 32'd1);
        check_eq("lo_first_cnt", 32'(err_cnt), 32'd1);
        drive(1'b1, 1'b1, 3'b111, 1'b1, 1'b0);
        check_eq("err_one_cycle", 32'(err), 32'd0);
        drive(1'b1, 1'b1, 3'b000, 1'b1, 1'b0);
        check_eq("hi_twice_err", 32'(err), 32'd1);
        drive(1'b1, 1'b0, 3'b111, 1'b1, 1'b0);
        check_eq("newest_hi_word", 32'(word_out), 32'b111000);
        check_eq("newest_hi_cnt", 32'(err_cnt), 32'd2);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);

        // clr in WAIT_LO, then a lower token is an error.
        drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
        check_eq("clr_err", 32'(err), 32'd1);
        check_eq("clr_no_word", 32'(out_valid), 32'd0);

        // clr coinciding with a handshake does not count the word.
        drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        check_eq("clr_hs_cnt", 32'(word_cnt), 32'd3);
        check_eq("clr_keeps_word", 32'(word_out), 32'b011011);

        // Saturation of err_cnt with back-to-back errors.
        repeat (257) drive(1'b1, 1'b0, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        check_eq("err_sat", 32'(err_cnt), 32'd255);
        check_eq("err_sat_pulse", 32'(err), 32'd1);

        // 3 words so far; 253 more wraps word_cnt to 0.
        repeat (253) send_word(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        check_eq("wrap_zero", 32'(word_cnt), 32'd0);
        repeat (3) send_word(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        check_eq("wrap_three", 32'(word_cnt), 32'd3);

        // Asynchronous reset while FULL, between clock edges.
        drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
        check_eq("pre_rst_full", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_word_cnt", 32'(word_cnt), 32'd0);
        check_eq("arst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("arst_word", 32'(word_out), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("arst_ready", 32'(in_ready), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_unpack.md
Name: switch_unpack

Overview:
- Receive-side counterpart of the sign-select 3-bit switch.
- The switch emits a 3-bit token: inverted x[5:3] when the sign bits match, inverted y[2:0] when they differ. This block accepts a tagged token stream and undoes the inversion.
- It pairs one upper-half token with one lower-half token into a 6-bit word, delivered over a valid/ready interface.
- Malformed ordering is detected, flagged and counted.

Parameters:
- CNT_W, 8, width of the word and error counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush of any partial or held word; counters kept.
- in_valid  input  1  a token is presented this cycle.
- in_ready  output  1  block can accept a token this cycle.
- in_sel  input  1  1 = token carries the upper half (sign-match path); 0 = lower half (sign-differ path).
- in_data  input  3  switch output token (inverted half).
- out_valid  output  1  word_out holds an assembled word.
- out_ready  input  1  downstream accepts word_out.
- word_out  output  6  reconstructed word {upper, lower}.
- err  output  1  one-cycle pulse on an out-of-order token.
- word_cnt  output  CNT_W  words delivered; wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  ordering errors; saturates at all-ones.

Behaviour:
- Reset (asynchronous):
  - state = WAIT_HI; hi_reg = 0.
  - word_out = 0, out_valid = 0, err = 0, word_cnt = 0, err_cnt = 0.
- Priority: rst > clr > normal operation.
- Accept rule: a token is accepted when in_valid && in_ready.
  - in_ready = 1 in WAIT_HI and WAIT_LO; 0 in FULL.
  - in_ready is registered-state based only, with no combinational path from out_ready.
- Inversion: every accepted token is recovered as ~in_data before storage.
- States and transitions:
  - WAIT_HI, accepted token with sel=1: hi_reg <= ~in_data; go to WAIT_LO.
  - WAIT_HI, accepted token with sel=0: token dropped; err pulses next cycle; err_cnt++; stay in WAIT_HI.
  - WAIT_LO, accepted token with sel=0: word_out <= {hi_reg, ~in_data}; out_valid <= 1; go to FULL. word_out is therefore visible one cycle after the lower token is accepted.
  - WAIT_LO, accepted token with sel=1: hi_reg is replaced by the new ~in_data; err pulse; err_cnt++; stay in WAIT_LO (the newest upper half wins).
  - FULL: word_out and out_valid are held stable until out_valid && out_ready. On that handshake: out_valid <= 0, word_cnt++, go to WAIT_HI. The next token can be accepted the cycle after the handshake.
- err is a registered single-cycle pulse and is never high for two cycles from one event.
- Consecutive errors on back-to-back cycles give consecutive pulses, and each one counts.
- err_cnt stops at 2^CNT_W-1; word_cnt rolls over to 0.
- clr:
  - Forces state to WAIT_HI and out_valid to 0, and drops any in_valid token in the same cycle.
  - hi_reg is cleared; word_out keeps its last value; counters and err are unaffected.
  - If clr coincides with an output handshake, the handshake does not count.
- in_valid = 0 in any state: no state change.
- Reset asserted mid-word or while FULL: everything returns to reset values immediately, independent of clk.
- word_out upper bits equal the original x[5:3]; lower bits equal the original y[2:0].

Test Plan:
- After reset, send (sel=1, data=010) then (sel=0, data=011), with out_ready=1 -> cycle after the second accept: out_valid=1, word_out=101100; word_cnt=1 after the handshake.
- Hold out_ready=0 in FULL for 5 cycles while in_valid=1 -> in_ready=0, word_out stable, no token consumed; raise out_ready -> one handshake, back to WAIT_HI.
- Send (sel=0, 000) in WAIT_HI -> err pulses 1 cycle, err_cnt=1, state stays WAIT_HI. Then send (sel=1, 111), (sel=1, 000), (sel=0, 111) -> one more err, and word_out=111000.
- Assert clr in WAIT_LO after the upper token 001 -> state WAIT_HI; a following (sel=0, x) is an error, not a word.
- Force 255 errors, then 2 more -> err_cnt holds at 255; deliver 256 words -> word_cnt wraps to 0.
- Assert rst asynchronously while FULL, between clock edges -> out_valid drops immediately, counters read 0, in_ready=1 after release.
